// File: rtl/player_board_ctrl_if.sv
// Board-side signal bundle of the player control front end.
// master = board/button side, slave = player_board_ctrl.
interface player_board_ctrl_if #(
  parameter int TRACK_W = 2
);
  logic               btn_play;
  logic               btn_next;
  logic               btn_prev;
  logic               player_done;
  logic               player_ce;
  logic               player_rst;
  logic [TRACK_W-1:0] track_sel;
  logic               playing;
  logic [3:0]         led;

  modport master (
    output btn_play, btn_next, btn_prev, player_done,
    input  player_ce, player_rst, track_sel, playing, led
  );

  modport slave (
    input  btn_play, btn_next, btn_prev, player_done,
    output player_ce, player_rst, track_sel, playing, led
  );
endinterface

// File: rtl/player_board_ctrl.sv
// Button conditioning plus play/pause/track sequencing for the PWM music player.
//   state    | meaning
//   IDLE     | player held in reset, next/prev only move the track
//   LOAD     | player reset for 2*CE_DIV cycles before playback starts
//   PLAY     | player running, player_ce every CE_DIV cycles
//   PAUSE    | player out of reset, ce stopped, divider phase kept
module player_board_ctrl #(
  parameter int CLK_FREQ     = 100000000,
  parameter int CE_DIV       = 2,
  parameter int NUM_TRACKS   = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_US  = 10000,
  parameter int AUTO_ADVANCE = 1
) (
  input logic                clk,
  input logic                reset,
  player_board_ctrl_if.slave bus
);

  localparam int TRACK_W = $clog2(NUM_TRACKS);
  localparam int DEB_CNT = CLK_FREQ / 1000000 * DEBOUNCE_US;
  localparam int CNT_W   = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam int DIV_W   = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam int LD_W    = $clog2(2 * CE_DIV);

  localparam logic [TRACK_W-1:0] TRACK_MAX = TRACK_W'(NUM_TRACKS - 1);
  localparam logic [CNT_W-1:0]   CNT_TC    = CNT_W'((DEB_CNT > 0) ? DEB_CNT - 1 : 0);
  localparam logic [DIV_W-1:0]   DIV_TC    = DIV_W'(CE_DIV - 1);
  localparam logic [LD_W-1:0]    LD_INIT   = LD_W'(2 * CE_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_PLAY, ST_PAUSE} state_t;

  logic [2:0]             btn_raw;
  logic [2:0]             synced;
  logic [2:0]             deb_q, deb_d;
  logic [2:0]             deb_prev_q;
  logic [2:0]             ev;
  logic [SYNC_STAGES-1:0] sync_q [3];
  logic [SYNC_STAGES-1:0] sync_d [3];
  logic [CNT_W-1:0]       cnt_q  [3];
  logic [CNT_W-1:0]       cnt_d  [3];

  assign btn_raw = {bus.btn_prev, bus.btn_next, bus.btn_play};

  // Level only flips after DEB_CNT consecutive disagreeing samples.
  always_comb begin
    for (int b = 0; b < 3; b++) begin
      sync_d[b] = {sync_q[b][SYNC_STAGES-2:0], btn_raw[b]};
      synced[b] = sync_q[b][SYNC_STAGES-1];
      deb_d[b]  = deb_q[b];
      cnt_d[b]  = '0;
      if (DEB_CNT == 0) begin
        deb_d[b] = synced[b];
      end else if (synced[b] != deb_q[b]) begin
        if (cnt_q[b] == CNT_TC) deb_d[b] = synced[b];
        else                    cnt_d[b] = cnt_q[b] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= '{default: '0};
      cnt_q      <= '{default: '0};
      deb_q      <= '0;
      deb_prev_q <= '0;
    end else begin
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
    end
  end

  assign ev = deb_q & ~deb_prev_q;

  state_t             state_q, state_d;
  logic [TRACK_W-1:0] track_q, track_d;
  logic [TRACK_W-1:0] trk_inc, trk_dec;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [LD_W-1:0]    ld_q, ld_d;
  logic               ce_q, ce_d;
  logic               rst_q, rst_d;
  logic               playing_q, playing_d;
  logic [3:0]         led_q, led_d;
  logic [1:0]         trk_lo;
  logic               play_ev, next_ev, prev_ev;

  assign play_ev = ev[0];
  assign next_ev = ev[1];
  assign prev_ev = ev[2];
  assign trk_inc = (track_q == TRACK_MAX) ? '0 : track_q + TRACK_W'(1);
  assign trk_dec = (track_q == '0) ? TRACK_MAX : track_q - TRACK_W'(1);

  always_comb begin
    state_d = state_q;
    track_d = track_q;
    ld_d    = ld_q;
    div_d   = div_q;
    case (state_q)
      ST_IDLE: begin
        if (play_ev) begin
          state_d = ST_LOAD;
          ld_d    = LD_INIT;
        end else if (next_ev) begin
          track_d = trk_inc;
        end else if (prev_ev) begin
          track_d = trk_dec;
        end
      end
      ST_LOAD: begin
        if (ld_q == '0) state_d = ST_PLAY;
        else            ld_d    = ld_q - LD_W'(1);
      end
      ST_PLAY: begin
        if (play_ev) begin
          state_d = ST_PAUSE;
        end else if (next_ev || prev_ev) begin
          state_d = ST_LOAD;
          ld_d    = LD_INIT;
          track_d = next_ev ? trk_inc : trk_dec;
        end else if (bus.player_done) begin
          if (AUTO_ADVANCE != 0) begin
            state_d = ST_LOAD;
            ld_d    = LD_INIT;
            track_d = trk_inc;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_PAUSE: begin
        if (play_ev) begin
          state_d = ST_PLAY;
        end else if (next_ev || prev_ev) begin
          state_d = ST_LOAD;
          ld_d    = LD_INIT;
          track_d = next_ev ? trk_inc : trk_dec;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Divider advances only across PLAY cycles; PAUSE keeps the phase.
    if (state_d == ST_PLAY) begin
      if (state_q == ST_PLAY || state_q == ST_PAUSE)
        div_d = (div_q == DIV_TC) ? '0 : div_q + DIV_W'(1);
      else
        div_d = '0;
    end else if (state_d != ST_PAUSE) begin
      div_d = '0;
    end

    ce_d      = (state_d == ST_PLAY) && (div_d == DIV_TC);
    rst_d     = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    playing_d = (state_d == ST_PLAY);
    trk_lo    = 2'(track_d);
    led_d     = {trk_lo, state_d == ST_PAUSE, playing_d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      track_q   <= '0;
      div_q     <= '0;
      ld_q      <= '0;
      ce_q      <= 1'b0;
      rst_q     <= 1'b1;
      playing_q <= 1'b0;
      led_q     <= '0;
    end else begin
      state_q   <= state_d;
      track_q   <= track_d;
      div_q     <= div_d;
      ld_q      <= ld_d;
      ce_q      <= ce_d;
      rst_q     <= rst_d;
      playing_q <= playing_d;
      led_q     <= led_d;
    end
  end

  assign bus.player_ce  = ce_q;
  assign bus.player_rst = rst_q;
  assign bus.track_sel  = track_q;
  assign bus.playing    = playing_q;
  assign bus.led        = led_q;

endmodule

// File: tb/tb_player_board_ctrl.sv
// Randomized scoreboard bench for player_board_ctrl, one instance per AUTO_ADVANCE setting.
module tb_player_board_ctrl;
  localparam int CE_DIV = 3;
  localparam int NTRK   = 3;
  localparam int SYNC   = 2;
  localparam int DEB    = 4;
  localparam int TW     = 2;
  localparam logic [8:0] RST_VEC = 9'b0_1_0_0000_00;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic b_play = 1'b0, b_next = 1'b0, b_prev = 1'b0, done = 1'b0;

  always #5 clk = ~clk;

  player_board_ctrl_if #(.TRACK_W(TW)) bus_a ();
  player_board_ctrl_if #(.TRACK_W(TW)) bus_n ();

  assign bus_a.btn_play = b_play;  assign bus_n.btn_play = b_play;
  assign bus_a.btn_next = b_next;  assign bus_n.btn_next = b_next;
  assign bus_a.btn_prev = b_prev;  assign bus_n.btn_prev = b_prev;
  assign bus_a.player_done = done; assign bus_n.player_done = done;

  player_board_ctrl #(.CLK_FREQ(1000000), .CE_DIV(CE_DIV), .NUM_TRACKS(NTRK),
    .SYNC_STAGES(SYNC), .DEBOUNCE_US(4), .AUTO_ADVANCE(1))
    u_dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));

  player_board_ctrl #(.CLK_FREQ(1000000), .CE_DIV(CE_DIV), .NUM_TRACKS(NTRK),
    .SYNC_STAGES(SYNC), .DEBOUNCE_US(4), .AUTO_ADVANCE(0))
    u_dut_n (.clk(clk), .reset(reset), .bus(bus_n.slave));

  // Reference model: debounce as "last DEB synced samples all disagree",
  // playback phase as a count of PLAY cycles since the last LOAD.
  typedef enum int {M_IDLE, M_LOAD, M_PLAY, M_PAUSE} mstate_t;
  mstate_t    m_st  [2];
  int         m_trk [2];
  int         m_lcyc[2];
  int         m_pc  [2];
  bit         hist  [3][$];
  bit         lvl   [3];
  bit         lvl_prev[3];
  logic [8:0] exp_q [2][$];
  int         n_checks = 0;
  int         n_fail   = 0;

  function automatic logic [8:0] model_out(int i);
    logic ce, rst, ply, pau;
    logic [1:0] t;
    ce  = (m_st[i] == M_PLAY) && ((m_pc[i] % CE_DIV) == CE_DIV - 1);
    rst = (m_st[i] == M_IDLE) || (m_st[i] == M_LOAD);
    ply = (m_st[i] == M_PLAY);
    pau = (m_st[i] == M_PAUSE);
    t   = 2'(m_trk[i]);
    return {ce, rst, ply, t, pau, ply, t};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = M_IDLE; m_trk[i] = 0; m_lcyc[i] = 0; m_pc[i] = 0;
    end
    for (int b = 0; b < 3; b++) begin
      hist[b].delete(); lvl[b] = 0; lvl_prev[b] = 0;
    end
  endfunction

  function automatic void model_step();
    bit ev[3];
    bit raw[3];
    bit all_diff;
    raw[0] = b_play; raw[1] = b_next; raw[2] = b_prev;
    for (int b = 0; b < 3; b++) begin
      ev[b] = lvl[b] && !lvl_prev[b];
      hist[b].push_front(raw[b]);
      all_diff = 1'b1;
      for (int k = SYNC; k < SYNC + DEB; k++)
        if (((k < hist[b].size()) ? hist[b][k] : 1'b0) == lvl[b]) all_diff = 1'b0;
      lvl_prev[b] = lvl[b];
      if (all_diff) lvl[b] = !lvl[b];
      while (hist[b].size() > SYNC + DEB) void'(hist[b].pop_back());
    end
    for (int i = 0; i < 2; i++) begin
      case (m_st[i])
        M_IDLE: begin
          if (ev[0]) begin m_st[i] = M_LOAD; m_lcyc[i] = 1; end
          else if (ev[1]) m_trk[i] = (m_trk[i] + 1) % NTRK;
          else if (ev[2]) m_trk[i] = (m_trk[i] + NTRK - 1) % NTRK;
        end
        M_LOAD: begin
          if (m_lcyc[i] == 2 * CE_DIV) begin m_st[i] = M_PLAY; m_pc[i] = 0; end
          else m_lcyc[i]++;
        end
        M_PLAY: begin
          if (ev[0]) m_st[i] = M_PAUSE;
          else if (ev[1] || ev[2]) begin
            m_trk[i] = ev[1] ? (m_trk[i] + 1) % NTRK : (m_trk[i] + NTRK - 1) % NTRK;
            m_st[i] = M_LOAD; m_lcyc[i] = 1;
          end else if (done) begin
            if (i == 0) begin
              m_trk[i] = (m_trk[i] + 1) % NTRK; m_st[i] = M_LOAD; m_lcyc[i] = 1;
            end else m_st[i] = M_IDLE;
          end else m_pc[i]++;
        end
        default: begin
          if (ev[0]) begin m_st[i] = M_PLAY; m_pc[i]++; end
          else if (ev[1] || ev[2]) begin
            m_trk[i] = ev[1] ? (m_trk[i] + 1) % NTRK : (m_trk[i] + NTRK - 1) % NTRK;
            m_st[i] = M_LOAD; m_lcyc[i] = 1;
          end
        end
      endcase
      exp_q[i].push_back(model_out(i));
    end
  endfunction

  always @(posedge clk) begin
    if (reset) model_step();
    else begin
      model_reset();
      for (int i = 0; i < 2; i++) exp_q[i].push_back(RST_VEC);
    end
  end

  always @(negedge reset) begin
    model_reset();
    for (int i = 0; i < 2; i++) exp_q[i].delete();
  end

  task automatic check(string name, int i, logic [8:0] act, logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got {ce,rst,play,led,trk}=%b expected %b at %0t",
               name, i, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [8:0] act [2];
    logic [8:0] exp;
    act[0] = {bus_a.player_ce, bus_a.player_rst, bus_a.playing, bus_a.led, bus_a.track_sel};
    act[1] = {bus_n.player_ce, bus_n.player_rst, bus_n.playing, bus_n.led, bus_n.track_sel};
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        if (exp_q[i].size() > 0) void'(exp_q[i].pop_front());
        check("reset_outputs", i, act[i], RST_VEC);
      end else if (exp_q[i].size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL scoreboard_underflow dut%0d: got empty queue required an entry at %0t", i, $time);
      end else begin
        exp = exp_q[i].pop_front();
        check("outputs", i, act[i], exp);
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic press(int mask, int hold, int rel, bit rnd_done);
    b_play = mask[0]; b_next = mask[1]; b_prev = mask[2];
    cyc(hold);
    b_play = 1'b0; b_next = 1'b0; b_prev = 1'b0;
    repeat (rel) begin
      done = rnd_done && !done && ($urandom_range(0, 11) == 0);
      cyc(1);
    end
    done = 1'b0;
  endtask

  initial begin
    int masks [11] = '{1, 2, 4, 1, 2, 4, 1, 3, 6, 5, 7};
    reset = 1'b0; cyc(5);
    reset = 1'b1; cyc(5);
    press(1, 12, 30, 0);          // play -> LOAD -> PLAY
    press(1, 3, 12, 0);           // glitch, ignored
    press(1, 1, 1, 0); press(1, 1, 1, 0);
    press(1, 10, 12, 0);          // bounce then steady -> PAUSE
    press(1, 10, 20, 0);          // resume
    press(2, 10, 25, 0);
    press(2, 10, 25, 0);
    press(4, 10, 25, 0);
    press(4, 10, 25, 0);
    press(6, 10, 25, 0);          // next+prev together
    done = 1'b1; cyc(1); done = 1'b0; cyc(25);
    press(1, 10, 20, 0);
    reset = 1'b0; cyc(3); reset = 1'b1; cyc(5);
    for (int n = 0; n < 220; n++) begin
      press(masks[$urandom_range(0, 10)], $urandom_range(1, 10), $urandom_range(2, 30), 1);
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b0; cyc($urandom_range(1, 3)); reset = 1'b1;
      end
    end
    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
